hello_scroll_ctrl: RTL and testbench

- Sequencer for the eight on-board hex letter decoders that show HELLO.
- Holds an 8-slot circular message: H, E, L, L, O, blank, blank, blank.
- Produces one 4-bit letter code per display (0 blank, 1 H, 2 E, 3 L, 4 L, 5 O), which the per-digit 7-segment decoders consume.
- Supports three display modes: static with manual stepping, timed scrolling, and timed blinking.

---
 rtl/hello_pkg.sv | 73 +++++++
 rtl/tick_prescaler.sv | 42 ++++
 rtl/hello_scroll_ctrl.sv | 124 ++++++++++++
 tb/tb_hello_scroll_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/hello_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hello_pkg
//  Description : Shared letter codes, HELLO message ROM, mode and state
//                encodings plus small helpers for the HELLO display sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package hello_pkg;

  // Letter codes understood by the per-digit 7-segment decoders
  localparam logic [3:0] L_BLANK = 4'd0;
  localparam logic [3:0] L_H     = 4'd1;
  localparam logic [3:0] L_E     = 4'd2;
  localparam logic [3:0] L_L1    = 4'd3;
  localparam logic [3:0] L_L2    = 4'd4;
  localparam logic [3:0] L_O     = 4'd5;

  // Circular message, element [s] is slot s (slot 0 = H)
  localparam logic [7:0][3:0] C_MSG_ROM = {
    L_BLANK, L_BLANK, L_BLANK, L_O, L_L2, L_L1, L_E, L_H
  };

  // Codes shown at offset 0: HEX7..HEX3 = HELLO, HEX2..HEX0 blank
  localparam logic [31:0] C_CODES_RST = 32'h1234_5000;

  // Mode input encodings (2'b11 falls back to static)
  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_SCROLL = 2'b01;
  localparam logic [1:0] MODE_BLINK  = 2'b10;

  typedef enum logic [1:0] {
    ST_STATIC = 2'd0,
    ST_SCROLL = 2'd1,
    ST_BLINK  = 2'd2
  } state_t;

  // Mode input to FSM state; the unused encoding behaves as static
  function automatic state_t mode_to_state(input logic [1:0] mode);
    state_t st;
    case (mode)
      MODE_SCROLL: st = ST_SCROLL;
      MODE_BLINK:  st = ST_BLINK;
      default:     st = ST_STATIC;
    endcase
    return st;
  endfunction

  // One rotation step: dir=0 moves the text left (offset+1), dir=1 right
  function automatic logic [2:0] step_offset(input logic [2:0] offset,
                                             input logic       dir);
    logic [2:0] nxt;
    if (dir) begin
      nxt = offset - 3'd1;
    end else begin
      nxt = offset + 3'd1;
    end
    return nxt;
  endfunction

  // HEXp shows slot ((7-p) + offset) mod 8; 3-bit sum gives the wrap for free
  function automatic logic [31:0] map_codes(input logic [2:0] offset);
    logic [31:0] codes;
    logic [2:0]  slot;
    codes = '0;
    for (int p = 0; p < 8; p++) begin
      slot              = 3'(7 - p) + offset;
      codes[4*p +: 4]   = C_MSG_ROM[slot];
    end
    return codes;
  endfunction

endpackage : hello_pkg
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Free-running divider producing a one-cycle tick every
//                TICK_DIV enabled cycles. Held at zero while disabled or
//                cleared, so the first tick after enabling is a full period.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
  parameter int TICK_DIV = 25000000,
  parameter int CNT_W    = 25
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == C_CNT_MAX);

  // Count 0..TICK_DIV-1 while enabled; clear/disable pins the count at zero
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr || !i_en) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + C_CNT_ONE;
    end
  end

  assign o_tick = i_en & w_wrap;

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/hello_scroll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hello_scroll_ctrl
//  Description : Sequencer for eight hex letter decoders showing HELLO.
//                Static with manual stepping, timed scrolling, timed blinking.
//                Codes is registered from offset, blink phase and state.
//  Revision    : 1.0 - initial release
// ============================================================================
module hello_scroll_ctrl
  import hello_pkg::*;
#(
  parameter int TICK_DIV = 25000000,
  parameter int CNT_W    = 25
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_mode,
  input  logic        i_dir,
  input  logic        i_step,
  output logic [31:0] o_codes,
  output logic [2:0]  o_offset,
  output logic        o_tick
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_state_chg;

  logic [2:0]  r_offset;
  logic [2:0]  w_offset_nxt;
  logic        r_blank;
  logic        w_blank_nxt;
  logic        r_step_q;
  logic        w_step_edge;
  logic        w_tick;
  logic        w_pre_en;
  logic [31:0] r_codes;
  logic [31:0] w_codes_nxt;

  // Prescaler runs only in the timed modes and restarts on every mode change
  assign w_pre_en    = (r_state != ST_STATIC);
  assign w_step_edge = i_step & ~r_step_q;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick_prescaler (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (w_pre_en),
    .i_clr  (w_state_chg),
    .o_tick (w_tick)
  );

  // State register: follows the mode input every cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_STATIC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, rotation and blink phase; a mode change beats tick and step
  always_comb begin
    w_state_nxt  = mode_to_state(i_mode);
    w_state_chg  = (w_state_nxt != r_state);
    w_offset_nxt = r_offset;
    w_blank_nxt  = r_blank;
    if (w_state_chg) begin
      w_blank_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_STATIC: begin
          if (w_step_edge) begin
            w_offset_nxt = step_offset(r_offset, i_dir);
          end
        end
        ST_SCROLL: begin
          if (w_tick) begin
            w_offset_nxt = step_offset(r_offset, i_dir);
          end
        end
        ST_BLINK: begin
          if (w_tick) begin
            w_blank_nxt = ~r_blank;
          end
        end
        default: begin
          w_offset_nxt = r_offset;
        end
      endcase
    end
  end

  // Output codes: blank during the off phase of blink, else rotated message
  always_comb begin
    w_codes_nxt = map_codes(r_offset);
    if ((r_state == ST_BLINK) && r_blank) begin
      w_codes_nxt = '0;
    end
  end

  // Datapath registers: offset, phase, step history and registered codes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_offset <= 3'd0;
      r_blank  <= 1'b0;
      r_step_q <= 1'b0;
      r_codes  <= C_CODES_RST;
    end else begin
      r_offset <= w_offset_nxt;
      r_blank  <= w_blank_nxt;
      r_step_q <= i_step;
      r_codes  <= w_codes_nxt;
    end
  end

  assign o_codes  = r_codes;
  assign o_offset = r_offset;
  assign o_tick   = w_tick;

endmodule : hello_scroll_ctrl
`default_nettype wire

// File: tb/tb_hello_scroll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hello_scroll_ctrl
//  Description : Self-checking bench for hello_scroll_ctrl with TICK_DIV=4.
//                A vector table holds per-cycle inputs and expected outputs;
//                expectations are queued when driven and compared after the
//                following clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hello_scroll_ctrl;

  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 3;

  // Hand-derived codes for each rotation offset 0..7
  localparam logic [31:0] C_TAB [8] = '{
    32'h12345000, 32'h23450001, 32'h34500012, 32'h45000123,
    32'h50001234, 32'h00012345, 32'h00123450, 32'h01234500
  };

  typedef struct {
    bit          rst;
    logic [1:0]  mode;
    bit          dir;
    bit          step;
    logic [31:0] codes;
    logic [2:0]  off;
    bit          tick;
  } vec_t;

  typedef struct {
    logic [31:0] codes;
    logic [2:0]  off;
    bit          tick;
    int          idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        dir;
  logic        step;
  logic [31:0] o_codes;
  logic [2:0]  o_offset;
  logic        o_tick;

  always #5 clk = ~clk;

  hello_scroll_ctrl #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_mode   (mode),
    .i_dir    (dir),
    .i_step   (step),
    .o_codes  (o_codes),
    .o_offset (o_offset),
    .o_tick   (o_tick)
  );

  task automatic add(input bit r, input logic [1:0] m, input bit d,
                     input bit s, input logic [31:0] c, input logic [2:0] o,
                     input bit t);
    vec_t v;
    v.rst = r; v.mode = m; v.dir = d; v.step = s;
    v.codes = c; v.off = o; v.tick = t;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic build();
    // Reset and hold in static
    add(1, 2'd0, 0, 0, C_TAB[0], 3'd0, 0);
    for (int i = 0; i < 3; i++) add(0, 2'd0, 0, 0, C_TAB[0], 3'd0, 0);
    // Scroll left for eight ticks: offset wraps back to 0
    for (int i = 0; i < 34; i++)
      add(0, 2'd1, 0, 0, C_TAB[(i == 0) ? 0 : ((i - 1) / 4) % 8],
          3'((i / 4) % 8), (i % 4) == 3);
    // Reset beats scroll, then scroll right by one tick
    add(1, 2'd1, 0, 0, C_TAB[0], 3'd0, 0);
    for (int i = 0; i < 6; i++)
      add(0, 2'd1, 1, 0, C_TAB[(i == 0) ? 0 : (8 - ((i - 1) / 4)) % 8],
          3'((8 - (i / 4)) % 8), (i % 4) == 3);
    // Scroll left to offset 5, then reset in the middle of scrolling
    add(1, 2'd0, 0, 0, C_TAB[0], 3'd0, 0);
    for (int i = 0; i < 22; i++)
      add(0, 2'd1, 0, 0, C_TAB[(i == 0) ? 0 : ((i - 1) / 4) % 8],
          3'((i / 4) % 8), (i % 4) == 3);
    add(1, 2'd1, 0, 0, C_TAB[0], 3'd0, 0);
    add(0, 2'd0, 0, 0, C_TAB[0], 3'd0, 0);
    add(0, 2'd0, 0, 0, C_TAB[0], 3'd0, 0);
    // Static: step held 10 cycles, released, pulsed once -> two advances
    add(0, 2'd0, 0, 1, C_TAB[0], 3'd1, 0);
    for (int i = 1; i < 10; i++) add(0, 2'd0, 0, 1, C_TAB[1], 3'd1, 0);
    add(0, 2'd0, 0, 0, C_TAB[1], 3'd1, 0);
    add(0, 2'd0, 0, 1, C_TAB[1], 3'd2, 0);
    add(0, 2'd0, 0, 0, C_TAB[2], 3'd2, 0);
    // Step with dir=1 moves back by one
    add(0, 2'd0, 1, 1, C_TAB[2], 3'd1, 0);
    add(0, 2'd0, 1, 0, C_TAB[1], 3'd1, 0);
    // Scroll with step toggling: only the tick advances
    for (int i = 0; i < 6; i++)
      add(0, 2'd1, 0, (i % 2) == 1, C_TAB[(i == 0) ? 1 : 1 + (i - 1) / 4],
          3'(1 + i / 4), (i % 4) == 3);
    // Back to static with step still high: no spurious advance
    add(0, 2'd0, 0, 1, C_TAB[2], 3'd2, 0);
    add(0, 2'd0, 0, 1, C_TAB[2], 3'd2, 0);
    add(0, 2'd0, 0, 0, C_TAB[2], 3'd2, 0);
    // Blink from offset 0: codes alternate every 4 cycles
    add(1, 2'd0, 0, 0, C_TAB[0], 3'd0, 0);
    for (int i = 0; i < 8; i++)
      add(0, 2'd2, 0, 0,
          ((i > 0) && ((((i - 1) / 4) % 2) == 1)) ? 32'h0 : C_TAB[0],
          3'd0, (i % 4) == 3);
    // Leave blink in a tick cycle while blank; re-entering blink is visible
    add(0, 2'd0, 0, 0, 32'h0, 3'd0, 0);
    add(0, 2'd0, 0, 0, C_TAB[0], 3'd0, 0);
    add(0, 2'd2, 0, 0, C_TAB[0], 3'd0, 0);
    add(0, 2'd2, 0, 0, C_TAB[0], 3'd0, 0);
    add(0, 2'd0, 0, 0, C_TAB[0], 3'd0, 0);
    // Scroll -> blink in the tick cycle: no advance, blink restarts its period
    for (int i = 0; i < 4; i++) add(0, 2'd1, 0, 0, C_TAB[0], 3'd0, (i % 4) == 3);
    add(0, 2'd2, 0, 0, C_TAB[0], 3'd0, 0);
    add(0, 2'd2, 0, 0, C_TAB[0], 3'd0, 0);
    add(0, 2'd2, 0, 0, C_TAB[0], 3'd0, 0);
    add(0, 2'd2, 0, 0, C_TAB[0], 3'd0, 1);
    add(0, 2'd2, 0, 0, C_TAB[0], 3'd0, 0);
    add(0, 2'd2, 0, 0, 32'h0,    3'd0, 0);
    // Mode 11 behaves as static: step works, prescaler never ticks
    add(1, 2'd0, 0, 0, C_TAB[0], 3'd0, 0);
    add(0, 2'd3, 0, 1, C_TAB[0], 3'd1, 0);
    for (int i = 0; i < 5; i++) add(0, 2'd3, 0, 0, C_TAB[1], 3'd1, 0);
  endtask

  initial begin
    rst  = 1'b1;
    mode = 2'd0;
    dir  = 1'b0;
    step = 1'b0;
    build();
    foreach (vecs[k]) begin
      exp_t e;
      exp_t g;
      @(negedge clk);
      rst  = vecs[k].rst;
      mode = vecs[k].mode;
      dir  = vecs[k].dir;
      step = vecs[k].step;
      e.codes = vecs[k].codes;
      e.off   = vecs[k].off;
      e.tick  = vecs[k].tick;
      e.idx   = k;
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      chk("codes",  g.idx, o_codes,                 g.codes);
      chk("offset", g.idx, {29'd0, o_offset},       {29'd0, g.off});
      chk("tick",   g.idx, {31'd0, o_tick},         {31'd0, g.tick});
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_hello_scroll_ctrl
`default_nettype wire
